// File: rtl/sobol_req_arbiter.sv
// sobol_req_arbiter
//   Shares one Sobol sample generator among NUM_REQ consumers. Each consumer
//   asks for a burst of N samples. Requests are served round-robin. The block
//   gates the generator's advance enable and counts in-flight samples so the
//   small output FIFO can never overflow. Samples leave on a valid/ready
//   stream tagged with the requester id and a last-of-burst flag.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   LEN_W      width of each burst-length field
//   GEN_LAT    cycles from a sobol_start=1 cycle to its sample on sobol_icdf
//   FIFO_DEPTH sample buffer entries (power of 2, >= GEN_LAT+1)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req / req_len        per-requester level request and burst length
//                        (field i = req_len[i*LEN_W +: LEN_W])
//   grant                one-hot, high from burst accept to burst completion
//   done                 one-cycle pulse when a burst completes
//   sobol_start          generator advance enable
//   sobol_icdf           generator sample input
//   out_valid/out_ready  output stream handshake
//   out_data/out_id      sample value and owning requester index
//   out_last             final sample of the burst
//   busy                 arbiter FSM not idle
//
// Optional build macro SOBOL_ARB_STATS_EN adds:
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//   burst_cnt  wrapping count of completed bursts
module sobol_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned GEN_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       done,
  output logic                       sobol_start,
  input  logic [15:0]                sobol_icdf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_last,
`ifdef SOBOL_ARB_STATS_EN
  output logic                       busy,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                burst_cnt
`else
  output logic                       busy
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   dlvd_q, dlvd_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               done_q, done_d;
  logic [GEN_LAT-1:0] pipe_q, pipe_d;

  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   inflight;

  logic               start;
  logic               push;
  logic               pop;
  logic               credit_ok;
  logic               drain_done;

  logic               arb_found;
  logic [ID_W-1:0]    arb_id;
  logic [ID_W-1:0]    cand;
  logic [LEN_W-1:0]   arb_len;

  // Samples issued to the generator but not yet captured into the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < GEN_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
  end

  // Occupied FIFO slots plus samples still in the generator pipe must stay
  // below the depth before another point may be requested.
  assign credit_ok  = ({1'b0, count_q} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);
  assign push       = pipe_q[GEN_LAT-1];
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign drain_done = (inflight == '0) && (count_q == '0) && (dlvd_q == len_q);

  // Round-robin pick: first asserted request at or after the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_len   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_id    = cand;
        arb_len   = req_len[cand*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    len_d    = len_q;
    issued_d = issued_q;
    dlvd_d   = pop ? dlvd_q + 1'b1 : dlvd_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    start    = 1'b0;
    pipe_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          id_d     = arb_id;
          len_d    = arb_len;
          issued_d = '0;
          dlvd_d   = '0;
          grant_d  = NUM_REQ'(1) << arb_id;
          state_d  = (arb_len == '0) ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        start = (issued_q != len_q) && credit_ok;
        if (start) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == len_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          done_d  = 1'b1;
          grant_d = '0;
          rr_d    = (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
          state_d = (|req) ? S_ARB : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pipe_d[0] = start;
    for (int unsigned i = 1; i < GEN_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      len_q    <= '0;
      issued_q <= '0;
      dlvd_q   <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      dlvd_q   <= dlvd_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      pipe_q   <= pipe_d;
    end
  end

  // FIFO pointers/occupancy; a simultaneous push and pop leaves count as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= sobol_icdf;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

  assign grant       = grant_q;
  assign done        = done_q;
  assign sobol_start = start;
  assign out_data    = out_valid ? mem_q[rd_q] : '0;
  assign out_id      = id_q;
  assign out_last    = out_valid && (dlvd_q == len_q - 1'b1);
  assign busy        = (state_q != S_IDLE);

`ifdef SOBOL_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] bursts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (done_q) bursts_q <= bursts_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign burst_cnt = bursts_q;
`endif

endmodule

// File: tb/tb_sobol_req_arbiter.sv
module tb_sobol_req_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned GEN_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ID_W       = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     done;
  logic                     sobol_start;
  logic [15:0]              sobol_icdf;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_last;
  logic                     busy;
`ifdef SOBOL_ARB_STATS_EN
  logic [15:0]              stall_cnt;
  logic [15:0]              burst_cnt;
`endif

  always #5 clk = ~clk;

  sobol_req_arbiter #(
    .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .GEN_LAT(GEN_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .grant(grant),
    .done(done), .sobol_start(sobol_start), .sobol_icdf(sobol_icdf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last),
`ifdef SOBOL_ARB_STATS_EN
    .busy(busy), .stall_cnt(stall_cnt), .burst_cnt(burst_cnt)
`else
    .busy(busy)
`endif
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, nothing expected at %0t", name, act, $time);
  endtask

  // Point n of the generator sequence: bit-reversed index (van der Corput).
  function automatic logic [15:0] pt(input int unsigned n);
    logic [15:0] v;
    logic [15:0] r;
    v = 16'(n + 1);
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Generator: advances on start; garbage appears on cycles with no sample.
  int unsigned gen_idx;
  logic [15:0] gpipe [GEN_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_idx <= 0;
      for (int i = 0; i < GEN_LAT; i++) gpipe[i] <= '0;
    end else begin
      gpipe[0] <= sobol_start ? pt(gen_idx) : 16'($urandom);
      if (sobol_start) gen_idx <= gen_idx + 1;
      for (int i = 1; i < GEN_LAT; i++) gpipe[i] <= gpipe[i-1];
    end
  end
  assign sobol_icdf = gpipe[GEN_LAT-1];

  // Reference model and scoreboard queues.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
    logic [15:0]     data;
  } samp_t;
  typedef struct {
    int unsigned id;
    int unsigned len;
  } burst_t;

  samp_t       exp_samp[$];
  burst_t      exp_burst[$];
  int unsigned pt_ctr;
  int unsigned rr_m;

  task automatic push_burst(input int unsigned id, input int unsigned len);
    burst_t b;
    b.id  = id;
    b.len = len;
    exp_burst.push_back(b);
    for (int unsigned k = 0; k < len; k++) begin
      samp_t s;
      s.id   = ID_W'(id);
      s.last = (k == len - 1);
      s.data = pt(pt_ctr);
      pt_ctr++;
      exp_samp.push_back(s);
    end
    rr_m = (id + 1) % NUM_REQ;
  endtask

  // All requesters in 'set' raised together: served in cyclic order from rr.
  task automatic predict(input logic [NUM_REQ-1:0] set, input logic [NUM_REQ*LEN_W-1:0] lens);
    int unsigned base;
    int unsigned idx;
    base = rr_m;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (base + k) % NUM_REQ;
      if (set[idx]) push_burst(idx, lens[idx*LEN_W +: LEN_W]);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents something.
  int unsigned burst_starts, starts_tot, pops_tot, samp_cnt;
  logic [NUM_REQ-1:0] prev_grant;
  samp_t  mon_s;
  burst_t mon_b;

  initial begin
    burst_starts = 0; starts_tot = 0; pops_tot = 0; samp_cnt = 0; prev_grant = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        burst_starts = 0; starts_tot = 0; pops_tot = 0; prev_grant = '0;
      end else begin
        if (sobol_start) begin
          check("credit", 64'((starts_tot - pops_tot) < FIFO_DEPTH), 64'(1));
          starts_tot++;
          burst_starts++;
        end
        if (out_valid && out_ready) begin
          if (exp_samp.size() == 0) fail_now("unexpected_sample", 64'({out_id, out_last, out_data}));
          else begin
            mon_s = exp_samp.pop_front();
            check("sample", 64'({out_id, out_last, out_data}), 64'(mon_s));
            samp_cnt++;
          end
          pops_tot++;
        end
        if (grant != prev_grant && grant != '0) begin
          if (exp_burst.size() == 0) fail_now("unexpected_grant", 64'(grant));
          else check("grant", 64'(grant), 64'(NUM_REQ'(1) << exp_burst[0].id));
        end
        prev_grant = grant;
        if (done) begin
          if (exp_burst.size() == 0) fail_now("unexpected_done", 64'(done));
          else begin
            mon_b = exp_burst.pop_front();
            check("burst_starts", 64'(burst_starts), 64'(mon_b.len));
          end
          burst_starts = 0;
        end
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  logic rnd_ready;
  logic scramble;

  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~grant;
    if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
    if (scramble)
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (grant[i]) req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((busy || exp_burst.size() != 0 || exp_samp.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now({name, "_timeout"}, 64'(exp_samp.size()));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({grant, done, sobol_start, out_valid, out_data, out_id, out_last, busy}), 64'(0));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_values");
    exp_samp.delete();
    exp_burst.delete();
    pt_ctr = 0;
    rr_m   = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned base;
    logic        saw;
    logic [NUM_REQ-1:0] set;

    rst_n = 1'b1; req = '0; req_len = '0; out_ready = 1'b1;
    rnd_ready = 1'b0; scramble = 1'b0; pt_ctr = 0; rr_m = 0;
    #1;
    apply_reset();

    // Single requester, len 3.
    req_len[0 +: LEN_W] = 3;
    predict(4'b0001, req_len);
    req = 4'b0001;
    tick();
    check("grant_after_1", 64'(grant), 64'(0));
    tick();
    check("grant_after_2", 64'(grant), 64'(4'b0001));
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("single_done_timeout", 64'(n));
    check("busy_after_done", 64'({busy, grant}), 64'(0));
    wait_idle("single", 200);

    // Contention: ids 1 and 3, then id 1 re-raised during id 3's burst.
    req_len[1*LEN_W +: LEN_W] = 2;
    req_len[3*LEN_W +: LEN_W] = 2;
    predict(4'b1010, req_len);
    push_burst(1, 2);
    req = 4'b1010;
    n = 0;
    while (grant != 4'b1000 && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("grant3_timeout", 64'(grant));
    req[1] = 1'b1;
    wait_idle("contention", 300);

    // Backpressure: len 10 with the consumer stalled.
    req_len[2*LEN_W +: LEN_W] = 10;
    predict(4'b0100, req_len);
    out_ready = 1'b0;
    req = 4'b0100;
    repeat (20) tick();
    check("bp_starts", 64'(burst_starts), 64'(FIFO_DEPTH));
    check("bp_start_low", 64'(sobol_start), 64'(0));
    check("bp_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    wait_idle("backpressure", 300);

    // Zero length burst.
    req_len[2*LEN_W +: LEN_W] = 0;
    predict(4'b0100, req_len);
    req = 4'b0100;
    n = 0; saw = 1'b0;
    while (!done && n < 100) begin tick(); saw = saw | out_valid | sobol_start; n++; end
    if (n >= 100) fail_now("zero_done_timeout", 64'(n));
    check("zero_no_activity", 64'(saw), 64'(0));
    wait_idle("zero", 100);

    // Pointer left at 3: id 3 must win over id 1.
    req_len[1*LEN_W +: LEN_W] = 1;
    req_len[3*LEN_W +: LEN_W] = 1;
    predict(4'b1010, req_len);
    req = 4'b1010;
    wait_idle("ptr3", 300);

    // Reset after 2 of 5 samples; requests held across reset.
    req_len[2*LEN_W +: LEN_W] = 5;
    predict(4'b0100, req_len);
    base = samp_cnt;
    req = 4'b0100;
    n = 0;
    while (samp_cnt < base + 2 && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("reset_wait_timeout", 64'(samp_cnt));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_burst");
    exp_samp.delete();
    exp_burst.delete();
    pt_ctr = 0;
    rr_m   = 0;
    req_len[1*LEN_W +: LEN_W] = 3;
    req_len[3*LEN_W +: LEN_W] = 2;
    req = 4'b1010;
    predict(4'b1010, req_len);
    tick();
    tick();
    rst_n = 1'b1;
    wait_idle("after_reset", 300);

    // Maximum length burst under random backpressure.
    rnd_ready = 1'b1;
    req_len[0 +: LEN_W] = 8'hFF;
    predict(4'b0001, req_len);
    req = 4'b0001;
    wait_idle("max_len", 3000);

    // Randomized batches with random lengths and random consumer readiness.
    scramble = 1'b1;
    for (int b = 0; b < 30; b++) begin
      set = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int unsigned i = 0; i < NUM_REQ; i++)
        req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 12));
      predict(set, req_len);
      req = set;
      wait_idle("random", 3000);
    end
    scramble  = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;

`ifdef SOBOL_ARB_STATS_EN
    // 4 + 3 stalled cycles over two bursts after a fresh reset.
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      req_len[s*LEN_W +: LEN_W] = LEN_W'(2 + s);
      predict(NUM_REQ'(1) << s, req_len);
      out_ready = 1'b0;
      req = NUM_REQ'(1) << s;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      if (n >= 100) fail_now("stats_valid_timeout", 64'(n));
      repeat (4 - s) tick();
      out_ready = 1'b1;
      wait_idle("stats", 200);
    end
    tick();
    check("stall_cnt", 64'(stall_cnt), 64'(7));
    check("burst_cnt", 64'(burst_cnt), 64'(2));
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobol_req_arbiter.md
Name: sobol_req_arbiter

Overview:
- Shares one Sobol generator (start in, 16-bit icdf out) among NUM_REQ consumers.
- Each consumer requests a burst of N samples.
- Round-robin grant; block gates the generator's start and tracks in-flight samples.
- Buffers icdf values in a small FIFO and returns them on a valid/ready stream tagged with requester id and a last flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 8, width of each burst-length field
- GEN_LAT, 2, cycles from a sobol_start=1 cycle to its sample on sobol_icdf
- FIFO_DEPTH, 4, sample buffer entries; must be >= GEN_LAT+1 and a power of 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester burst request, level, held until grant
- req_len  in  NUM_REQ*LEN_W  burst length per requester; field i = bits [i*LEN_W +: LEN_W]
- grant  out  NUM_REQ  one-hot; high from burst accept through burst completion
- done  out  1  one-cycle pulse when a burst completes
- sobol_start  out  1  generator advance enable
- sobol_icdf  in  16  generator sample
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts
- out_data  out  16  sample value
- out_id  out  $clog2(NUM_REQ)  index of the granted requester
- out_last  out  1  final sample of the burst
- busy  out  1  FSM not in IDLE

Behaviour:
- Generator contract: advances one point per cycle while sobol_start=1 and holds while 0. The sample for an enabled cycle t appears on sobol_icdf at t+GEN_LAT.
- Reset values: grant=0, done=0, sobol_start=0, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0. FIFO empty, in-flight pipe cleared, RR pointer=0, FSM=IDLE.
- FSM states: IDLE, ARB, RUN, DRAIN.
  - IDLE -> ARB when |req.
  - ARB (1 cycle): pick the first asserted req at or after the RR pointer, wrapping modulo NUM_REQ. Latch id and req_len[id]; assert grant[id] next cycle.
    - len==0: DRAIN directly, no samples issued.
    - otherwise: RUN.
  - RUN: sobol_start=1 iff issued<len AND (fifo_count + inflight) < FIFO_DEPTH (credit check, combinational on registered counts). Each start cycle increments issued and pushes a 1 into a GEN_LAT-deep valid shift register.
  - RUN -> DRAIN when issued==len, evaluated on the cycle issuing the last point.
  - DRAIN: sobol_start=0. Wait until inflight==0 and FIFO empty with the last sample accepted. Then pulse done, drop grant, set RR pointer = id+1 mod NUM_REQ, go to ARB if |req, else IDLE.
- Capture: when the shift-register tail is 1, write sobol_icdf to the FIFO that cycle. The credit check guarantees no overflow; overflow is an assertion failure.
- Output stream:
  - out_valid = FIFO not empty; out_data is the FIFO head.
  - Handshake on out_valid & out_ready. Data, id and last stay stable while valid & !ready.
  - out_last=1 on the head entry when delivered count == len-1.
- Simultaneous capture and pop in the same cycle: FIFO count unchanged.
- req deasserted mid-burst: ignored; the burst runs to completion.
- req_len changed after ARB: ignored, since the length is latched.
- rst_n low mid-burst: immediate return to reset values; in-flight samples discarded.
- Widths: issued/delivered counters are LEN_W bits. Max burst = 2^LEN_W-1.

Optional Feature:
- Macro SOBOL_ARB_STATS_EN.
- When defined, adds output stall_cnt (16 bits): increments each cycle out_valid & !out_ready, saturates at 16'hFFFF, resets to 0 on rst_n only.
- Also adds output burst_cnt (16 bits): increments on each done pulse, wraps.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single requester: req[0]=1, len=3, out_ready=1 -> grant=4'b0001 two cycles later; exactly 3 start cycles; 3 samples out in generator order with id=0; last on the third; done pulse; busy=0 after.
- Contention: req=4'b1010, len=2 each -> bursts served in order id 1 then id 3. Re-assert req[1] during id 3's burst -> id 1 next, pointer wraps.
- Backpressure: len=10, out_ready=0 for 20 cycles -> sobol_start stops once fifo+inflight=4. No FIFO overflow, no lost or duplicated sample. Release -> all 10 samples in order.
- Zero length: req[2]=1, len=0 -> grant[2] for one burst, no start, no out_valid, done pulse, pointer=3.
- Reset mid-burst: rst_n=0 after 2 of 5 samples -> all outputs at reset values that cycle. After release with req held, a new burst starts from pointer 0.
- With SOBOL_ARB_STATS_EN: 7 stalled cycles over two bursts -> stall_cnt=7, burst_cnt=2.
